// File: rtl/l1_dcache_if.sv
// Core-side and pmem-side signal bundle for the L1 data cache.
// slave is the cache's view; master is the surrounding core/memory view.
interface l1_dcache_if;
  // Core dcache port
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  // Line-transfer port toward the cacheline adaptor
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp,
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp
  );

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp,
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Hits complete combinationally; misses write back a dirty victim, then fill.
module l1_dcache #(
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned S_OFFSET = 5
) (
  input logic        clk,
  input logic        rst,
  l1_dcache_if.slave bus
);

  localparam int unsigned NumSets = 2 ** S_INDEX;
  localparam int unsigned TagW    = 32 - S_OFFSET - S_INDEX;

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e              state_q;
  logic [NumSets-1:0]  valid_q;
  logic [NumSets-1:0]  dirty_q;
  logic [TagW-1:0]     tag_q  [NumSets];
  logic [255:0]        data_q [NumSets];

  // Set/tag of the miss being serviced, so a withdrawn request can't redirect it
  logic [S_INDEX-1:0]  miss_index_q;
  logic [TagW-1:0]     miss_tag_q;

  logic                pmem_read_q;
  logic                pmem_write_q;
  logic [31:0]         pmem_address_q;
  logic [255:0]        pmem_wdata_q;

  logic [S_INDEX-1:0]  req_index;
  logic [TagW-1:0]     req_tag;
  logic [2:0]          req_word;
  logic                req;
  logic                hit;
  logic [255:0]        cur_line;
  logic [31:0]         cur_word;
  logic [31:0]         merged_word;
  logic [255:0]        merged_line;

  assign req_index = bus.mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign req_tag   = bus.mem_address[31:S_OFFSET+S_INDEX];
  assign req_word  = bus.mem_address[4:2];
  assign req       = bus.mem_read | bus.mem_write;
  assign cur_line  = data_q[req_index];
  assign cur_word  = cur_line[{req_word, 5'b0} +: 32];

  assign hit = (state_q == StIdle) && req && valid_q[req_index] && (tag_q[req_index] == req_tag);

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) begin
        merged_word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
      end
    end
    merged_line = cur_line;
    merged_line[{req_word, 5'b0} +: 32] = merged_word;
  end

  assign bus.mem_resp     = hit;
  assign bus.mem_rdata    = hit ? cur_word : 32'h0;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      valid_q        <= '0;
      dirty_q        <= '0;
      miss_index_q   <= '0;
      miss_tag_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= 32'h0;
      pmem_wdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            // Write wins when both strobes are high; an empty mask still marks dirty
            if (bus.mem_write) begin
              data_q[req_index]  <= merged_line;
              dirty_q[req_index] <= 1'b1;
            end
          end else if (req) begin
            miss_index_q <= req_index;
            miss_tag_q   <= req_tag;
            if (valid_q[req_index] && dirty_q[req_index]) begin
              state_q        <= StWriteback;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {tag_q[req_index], req_index, {S_OFFSET{1'b0}}};
              pmem_wdata_q   <= cur_line;
            end else begin
              state_q        <= StFill;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_tag, req_index, {S_OFFSET{1'b0}}};
            end
          end
        end

        StWriteback: begin
          if (bus.pmem_resp) begin
            dirty_q[miss_index_q] <= 1'b0;
            state_q               <= StFill;
            pmem_write_q          <= 1'b0;
            pmem_read_q           <= 1'b1;
            pmem_address_q        <= {miss_tag_q, miss_index_q, {S_OFFSET{1'b0}}};
          end
        end

        StFill: begin
          if (bus.pmem_resp) begin
            data_q[miss_index_q]  <= bus.pmem_rdata;
            tag_q[miss_index_q]   <= miss_tag_q;
            valid_q[miss_index_q] <= 1'b1;
            dirty_q[miss_index_q] <= 1'b0;
            state_q               <= StIdle;
            pmem_read_q           <= 1'b0;
          end
        end

        default: begin
          state_q      <= StIdle;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed self-checking bench for l1_dcache: inputs driven on the falling edge,
// combinational outputs sampled 1ns later, registered outputs on the falling edge.
module tb_l1_dcache;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  l1_dcache_if bus ();

  l1_dcache #(
    .S_INDEX  (3),
    .S_OFFSET (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [255:0] line1;
  logic [255:0] line1_merged;
  logic [255:0] line2;
  logic [255:0] line3;
  logic [255:0] line4;
  logic [255:0] line5;

  task automatic drive_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mbe);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = mbe;
  endtask

  task automatic clear_req();
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_req();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp: got %b want 0", bus.mem_resp); end
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b want 0", bus.pmem_read); end
    checks++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b want 0", bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_address: got %h want 0", bus.pmem_address); end
    checks++; if (bus.pmem_wdata !== 256'h0) begin errors++; $display("FAIL reset_pmem_wdata: got %h want 0", bus.pmem_wdata); end
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL idle_no_req_pmem_read: got %b want 0", bus.pmem_read); end
  endtask

  task automatic test_read_miss_fill();
    drive_req(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL miss_no_resp: got %b want 0", bus.mem_resp); end
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL fill_pmem_read: got %b want 1", bus.pmem_read); end
    checks++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL fill_pmem_write: got %b want 0", bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h40) begin errors++; $display("FAIL fill_address: got %h want 00000040", bus.pmem_address); end
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL fill_held: got %b want 1", bus.pmem_read); end
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL fill_wait_resp: got %b want 0", bus.mem_resp); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    #1;
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL fill_done_pmem_read: got %b want 0", bus.pmem_read); end
    checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL fill_then_resp: got %b want 1", bus.mem_resp); end
    checks++; if (bus.mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fill_then_rdata: got %h want deadbeef", bus.mem_rdata); end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_read_hit();
    drive_req(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL hit_resp: got %b want 1", bus.mem_resp); end
    checks++; if (bus.mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_rdata: got %h want deadbeef", bus.mem_rdata); end
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++; $display("FAIL hit_no_pmem: got r=%b w=%b want 0/0", bus.pmem_read, bus.pmem_write);
    end
    drive_req(1'b1, 1'b0, 32'h5C, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_rdata !== 32'h77777777) begin errors++; $display("FAIL hit_word7: got %h want 77777777", bus.mem_rdata); end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_write_hit();
    drive_req(1'b0, 1'b1, 32'h40, 32'h12345678, 4'b0011);
    #1;
    checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL write_hit_resp: got %b want 1", bus.mem_resp); end
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_rdata !== 32'hAAAA5678) begin errors++; $display("FAIL write_merge: got %h want aaaa5678", bus.mem_rdata); end
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'h44, 32'hFFFFFFFF, 4'b0000);
    #1;
    checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL write_mbe0_resp: got %b want 1", bus.mem_resp); end
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_mbe0_data: got %h want deadbeef", bus.mem_rdata); end
    @(negedge clk);
    // Both strobes high: write must win
    drive_req(1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 4'b1111);
    #1;
    checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL rw_both_resp: got %b want 1", bus.mem_resp); end
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h48, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_both_write_wins: got %h want cafef00d", bus.mem_rdata); end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_dirty_evict();
    drive_req(1'b1, 1'b0, 32'h140, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL evict_no_resp: got %b want 0", bus.mem_resp); end
    @(negedge clk);
    checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin
      errors++; $display("FAIL wb_strobes: got w=%b r=%b want 1/0", bus.pmem_write, bus.pmem_read);
    end
    checks++; if (bus.pmem_address !== 32'h40) begin errors++; $display("FAIL wb_address: got %h want 00000040", bus.pmem_address); end
    checks++; if (bus.pmem_wdata !== line1_merged) begin errors++; $display("FAIL wb_wdata: got %h want %h", bus.pmem_wdata, line1_merged); end
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b1) begin
      errors++; $display("FAIL wb_to_fill: got w=%b r=%b want 0/1", bus.pmem_write, bus.pmem_read);
    end
    checks++; if (bus.pmem_address !== 32'h140) begin errors++; $display("FAIL wb_fill_address: got %h want 00000140", bus.pmem_address); end
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL wb_fill_resp: got %b want 0", bus.mem_resp); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line2;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    #1;
    checks++; if (bus.mem_resp !== 1'b1) begin errors++; $display("FAIL evict_resp: got %b want 1", bus.mem_resp); end
    checks++; if (bus.mem_rdata !== 32'h14000000) begin errors++; $display("FAIL evict_rdata: got %h want 14000000", bus.mem_rdata); end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_clean_evict();
    drive_req(1'b1, 1'b0, 32'h244, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b1) begin
      errors++; $display("FAIL clean_strobes: got w=%b r=%b want 0/1", bus.pmem_write, bus.pmem_read);
    end
    checks++; if (bus.pmem_address !== 32'h240) begin errors++; $display("FAIL clean_address: got %h want 00000240", bus.pmem_address); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line3;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    #1;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h24000001) begin
      errors++; $display("FAIL clean_read: got resp=%b data=%h want 1/24000001", bus.mem_resp, bus.mem_rdata);
    end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_idle_pmem_resp();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {8{32'hBADBAD00}};
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++; $display("FAIL idle_resp_strobes: got r=%b w=%b want 0/0", bus.pmem_read, bus.pmem_write);
    end
    drive_req(1'b1, 1'b0, 32'h244, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h24000001) begin
      errors++; $display("FAIL idle_resp_ignored: got resp=%b data=%h want 1/24000001", bus.mem_resp, bus.mem_rdata);
    end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_abandon();
    drive_req(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    @(negedge clk);
    clear_req();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h80) begin
      errors++; $display("FAIL abandon_fill: got r=%b addr=%h want 1/00000080", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line4;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    #1;
    checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
      errors++; $display("FAIL abandon_quiet: got resp=%b r=%b want 0/0", bus.mem_resp, bus.pmem_read);
    end
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h8C, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h08000003) begin
      errors++; $display("FAIL abandon_line_kept: got resp=%b data=%h want 1/08000003", bus.mem_resp, bus.mem_rdata);
    end
    @(negedge clk);
    clear_req();
  endtask

  task automatic test_reset_mid_fill();
    drive_req(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h300) begin
      errors++; $display("FAIL rstfill_start: got r=%b addr=%h want 1/00000300", bus.pmem_read, bus.pmem_address);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++; $display("FAIL rstfill_drop: got r=%b w=%b want 0/0", bus.pmem_read, bus.pmem_write);
    end
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL rstfill_resp: got %b want 0", bus.mem_resp); end
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h300) begin
      errors++; $display("FAIL rstfill_restart: got r=%b addr=%h want 1/00000300", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line5;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    #1;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h30000000) begin
      errors++; $display("FAIL rstfill_read: got resp=%b data=%h want 1/30000000", bus.mem_resp, bus.mem_rdata);
    end
    @(negedge clk);
    // Reset invalidated every set, so 0x244 (filled earlier) must miss again
    drive_req(1'b1, 1'b0, 32'h244, 32'h0, 4'h0);
    #1;
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL rst_invalidates: got resp %b want 0", bus.mem_resp); end
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin
      errors++; $display("FAIL rst_refill_strobes: got r=%b w=%b want 1/0", bus.pmem_read, bus.pmem_write);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = line3;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    clear_req();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    line1        = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                    32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'hAAAAAAAA};
    line1_merged = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                    32'h33333333, 32'hCAFEF00D, 32'hDEADBEEF, 32'hAAAA5678};
    line2        = {32'h14000007, 32'h14000006, 32'h14000005, 32'h14000004,
                    32'h14000003, 32'h14000002, 32'h14000001, 32'h14000000};
    line3        = {32'h24000007, 32'h24000006, 32'h24000005, 32'h24000004,
                    32'h24000003, 32'h24000002, 32'h24000001, 32'h24000000};
    line4        = {32'h08000007, 32'h08000006, 32'h08000005, 32'h08000004,
                    32'h08000003, 32'h08000002, 32'h08000001, 32'h08000000};
    line5        = {32'h30000007, 32'h30000006, 32'h30000005, 32'h30000004,
                    32'h30000003, 32'h30000002, 32'h30000001, 32'h30000000};
    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_clean_evict();
    test_idle_pmem_resp();
    test_abandon();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
